// File: rtl/cl_pcim_ot_limiter.sv
// PCIM outstanding-transaction limiter.
// Gates AW/AR issue against registered outstanding counts and a drain FSM.
// It also watches B / R-last completions to track outstanding counts,
// per-direction response timeouts, and counter underflow.

// Per-direction tracker: outstanding count, idle timer, sticky timeout.
module cl_pcim_ot_dir #(
  parameter int MAX_OT = 16
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        issue_i,
  input  logic        cmpl_i,
  input  logic        clr_err_i,
  input  logic [31:0] cfg_timeout_i,
  output logic [7:0]  cnt_o,
  output logic        full_o,
  output logic        timeout_o,
  output logic        uflow_o
);
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] idle_q, idle_d;
  logic        to_q, to_d;

  // Count update: issue and completion in the same cycle cancel out.
  // A completion with nothing outstanding holds the count at 0 and flags underflow.
  always_comb begin
    cnt_d   = cnt_q;
    uflow_o = 1'b0;
    if (issue_i && !cmpl_i) begin
      cnt_d = cnt_q + 8'd1;
    end else if (cmpl_i && !issue_i) begin
      if (cnt_q == 8'd0) uflow_o = 1'b1;
      else               cnt_d   = cnt_q - 8'd1;
    end
  end

  // Idle timer: counts cycles with traffic outstanding but no completion.
  // The timer saturates at all-ones.
  always_comb begin
    idle_d = idle_q;
    if (clr_err_i || cnt_q == 8'd0 || cmpl_i) idle_d = '0;
    else if (idle_q != '1)                    idle_d = idle_q + 32'd1;
  end

  // Sticky timeout. A set in the same cycle as clr_err wins.
  always_comb begin
    to_d = to_q;
    if (cfg_timeout_i != 32'd0 && idle_q == cfg_timeout_i) to_d = 1'b1;
    else if (clr_err_i)                                    to_d = 1'b0;
  end

  // Register the tracker state.
  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_q  <= '0;
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign full_o    = (cnt_q == 8'(MAX_OT));
  assign timeout_o = to_q;
endmodule

module cl_pcim_ot_limiter #(
  parameter int MAX_WR_OT = 16,
  parameter int MAX_RD_OT = 32,
  parameter int AXD_W     = 91
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             s_aw_valid,
  output logic             s_aw_ready,
  input  logic [AXD_W-1:0] s_aw_data,
  output logic             m_aw_valid,
  input  logic             m_aw_ready,
  output logic [AXD_W-1:0] m_aw_data,
  input  logic             s_ar_valid,
  output logic             s_ar_ready,
  input  logic [AXD_W-1:0] s_ar_data,
  output logic             m_ar_valid,
  input  logic             m_ar_ready,
  output logic [AXD_W-1:0] m_ar_data,
  input  logic             b_valid,
  input  logic             b_ready,
  input  logic             r_valid,
  input  logic             r_ready,
  input  logic             r_last,
  input  logic [31:0]      cfg_timeout,
  input  logic             drain_req,
  input  logic             clr_err,
  output logic [7:0]       wr_ot_cnt,
  output logic [7:0]       rd_ot_cnt,
  output logic             drain_done,
  output logic             wr_timeout,
  output logic             rd_timeout,
  output logic             ot_underflow
);
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0] state_q, state_d;
  logic       drain_done_q, uf_q;
  logic       wr_full, rd_full, wr_block, rd_block;
  logic       wr_issue, rd_issue, b_cmpl, r_cmpl, wr_uf, rd_uf;

  // Payloads pass straight through; only the handshakes are gated.
  assign m_aw_data = s_aw_data;
  assign m_ar_data = s_ar_data;

  // Gating looks only at registered count and state. A slot freed this cycle is not reused until next cycle.
  assign wr_block   = wr_full | (state_q != ST_RUN);
  assign rd_block   = rd_full | (state_q != ST_RUN);
  assign m_aw_valid = s_aw_valid & ~wr_block;
  assign s_aw_ready = m_aw_ready & ~wr_block;
  assign m_ar_valid = s_ar_valid & ~rd_block;
  assign s_ar_ready = m_ar_ready & ~rd_block;

  assign wr_issue = m_aw_valid & m_aw_ready;
  assign rd_issue = m_ar_valid & m_ar_ready;
  assign b_cmpl   = b_valid & b_ready;
  assign r_cmpl   = r_valid & r_ready & r_last;

  cl_pcim_ot_dir #(.MAX_OT(MAX_WR_OT)) u_wr (
    .aclk(aclk), .rst(rst), .issue_i(wr_issue), .cmpl_i(b_cmpl),
    .clr_err_i(clr_err), .cfg_timeout_i(cfg_timeout),
    .cnt_o(wr_ot_cnt), .full_o(wr_full), .timeout_o(wr_timeout), .uflow_o(wr_uf)
  );

  cl_pcim_ot_dir #(.MAX_OT(MAX_RD_OT)) u_rd (
    .aclk(aclk), .rst(rst), .issue_i(rd_issue), .cmpl_i(r_cmpl),
    .clr_err_i(clr_err), .cfg_timeout_i(cfg_timeout),
    .cnt_o(rd_ot_cnt), .full_o(rd_full), .timeout_o(rd_timeout), .uflow_o(rd_uf)
  );

  // Drain FSM. Dropping drain_req always returns to RUN, even mid-drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)                                 state_d = ST_RUN;
        else if (wr_ot_cnt == 8'd0 && rd_ot_cnt == 8'd0) state_d = ST_DRAINED;
      end
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // Register the FSM, drain_done, and sticky underflow. A set in the same cycle as clr_err wins.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= (state_d == ST_DRAINED);
      if (wr_uf || rd_uf) uf_q <= 1'b1;
      else if (clr_err)   uf_q <= 1'b0;
    end
  end

  assign drain_done   = drain_done_q;
  assign ot_underflow = uf_q;
endmodule

// File: tb/tb_cl_pcim_ot_limiter.sv
// Scoreboard bench for cl_pcim_ot_limiter.
// The driver pushes the model's expected outputs for each cycle.
// A negedge monitor pops each expectation and compares it against the DUT.
module tb_cl_pcim_ot_limiter;
  localparam int MW = 16, MR = 32, W = 91;
  localparam int MRUN = 0, MDRAIN = 1, MDRAINED = 2;

  logic aclk = 1'b0, rst;
  logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [W-1:0] s_aw_data, m_aw_data, s_ar_data, m_ar_data;
  logic b_valid, b_ready, r_valid, r_ready, r_last;
  logic [31:0] cfg_timeout;
  logic drain_req, clr_err;
  logic [7:0] wr_ot_cnt, rd_ot_cnt;
  logic drain_done, wr_timeout, rd_timeout, ot_underflow;

  cl_pcim_ot_limiter #(.MAX_WR_OT(MW), .MAX_RD_OT(MR), .AXD_W(W)) dut (
    .aclk(aclk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_data(s_aw_data),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_data(m_aw_data),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_data(s_ar_data),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_data(m_ar_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .cfg_timeout(cfg_timeout), .drain_req(drain_req), .clr_err(clr_err),
    .wr_ot_cnt(wr_ot_cnt), .rd_ot_cnt(rd_ot_cnt), .drain_done(drain_done),
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout), .ot_underflow(ot_underflow)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic awv, awr, arv, arr;
    logic [W-1:0] awd, ard;
    logic [7:0] wc, rc;
    logic dd, wto, rto, uf;
  } obs_t;

  obs_t expq[$];
  int n_chk = 0, n_fail = 0;

  // Reference model: transaction counts, idle-cycle counts, mode, sticky flags.
  int m_wr, m_rd, m_mode;
  longint m_wi, m_ri;
  bit m_wto, m_rto, m_uf;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_mode = MRUN; m_wi = 0; m_ri = 0;
    m_wto = 0; m_rto = 0; m_uf = 0;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    bit bw, br;
    bw = (m_wr >= MW) || (m_mode != MRUN);
    br = (m_rd >= MR) || (m_mode != MRUN);
    o.awv = s_aw_valid && !bw;  o.awr = m_aw_ready && !bw;
    o.arv = s_ar_valid && !br;  o.arr = m_ar_ready && !br;
    o.awd = s_aw_data;          o.ard = s_ar_data;
    o.wc = 8'(m_wr);            o.rc = 8'(m_rd);
    o.dd = (m_mode == MDRAINED);
    o.wto = m_wto; o.rto = m_rto; o.uf = m_uf;
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.awv = m_aw_valid; o.awr = s_aw_ready; o.arv = m_ar_valid; o.arr = s_ar_ready;
    o.awd = m_aw_data;  o.ard = m_ar_data;
    o.wc = wr_ot_cnt;   o.rc = rd_ot_cnt;
    o.dd = drain_done;  o.wto = wr_timeout; o.rto = rd_timeout; o.uf = ot_underflow;
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit iw, ir, cw, cr, ufs, ws, rs;
    int ow, orr;
    if (rst) begin model_reset(); return; end
    ow = m_wr; orr = m_rd; ufs = 0;
    iw = s_aw_valid && m_aw_ready && m_mode == MRUN && ow < MW;
    ir = s_ar_valid && m_ar_ready && m_mode == MRUN && orr < MR;
    cw = b_valid && b_ready;
    cr = r_valid && r_ready && r_last;
    if (iw && !cw) m_wr = ow + 1;
    else if (cw && !iw) begin if (ow == 0) ufs = 1; else m_wr = ow - 1; end
    if (ir && !cr) m_rd = orr + 1;
    else if (cr && !ir) begin if (orr == 0) ufs = 1; else m_rd = orr - 1; end
    ws = (cfg_timeout != 0) && (m_wi == cfg_timeout);
    rs = (cfg_timeout != 0) && (m_ri == cfg_timeout);
    m_wi = (clr_err || ow == 0 || cw) ? 0 : (m_wi < 64'hFFFF_FFFF ? m_wi + 1 : m_wi);
    m_ri = (clr_err || orr == 0 || cr) ? 0 : (m_ri < 64'hFFFF_FFFF ? m_ri + 1 : m_ri);
    m_wto = ws ? 1'b1 : (clr_err ? 1'b0 : m_wto);
    m_rto = rs ? 1'b1 : (clr_err ? 1'b0 : m_rto);
    m_uf  = ufs ? 1'b1 : (clr_err ? 1'b0 : m_uf);
    case (m_mode)
      MRUN:    if (drain_req) m_mode = MDRAIN;
      MDRAIN:  if (!drain_req) m_mode = MRUN; else if (ow == 0 && orr == 0) m_mode = MDRAINED;
      default: if (!drain_req) m_mode = MRUN;
    endcase
  endtask

  // One cycle: record what the DUT must show now, then take the edge.
  task automatic tick();
    expq.push_back(model_out());
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    s_aw_valid = 0; s_ar_valid = 0; b_valid = 0; b_ready = 0;
    r_valid = 0; r_ready = 0; r_last = 0; drain_req = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  // Monitor: compare the DUT against each queued expectation on the falling edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge aclk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = dut_out();
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard at %0t: actual=%h expected=%h", $time, a, e);
        end
      end
    end
  end

  initial begin
    int n;
    logic [95:0] t;
    idle_inputs();
    m_aw_ready = 1; m_ar_ready = 1; cfg_timeout = 0;
    s_aw_data = '0; s_ar_data = '0;
    rst = 1;
    @(posedge aclk); model_reset(); #1;
    tick(); rst = 0;
    chk("reset_wcnt", wr_ot_cnt, 0);
    chk("reset_rcnt", rd_ot_cnt, 0);
    chk("reset_drain_done", drain_done, 0);

    // Fill the write side to its limit, then free one slot.
    s_aw_valid = 1;
    repeat (20) tick();
    chk("wr_limit_cnt", wr_ot_cnt, 16);
    chk("wr_limit_valid", m_aw_valid, 0);
    b_valid = 1; b_ready = 1; tick(); b_valid = 0;
    chk("wr_after_b_cnt", wr_ot_cnt, 15);
    chk("wr_reissue_valid", m_aw_valid, 1);
    tick();
    chk("wr_refill_cnt", wr_ot_cnt, 16);

    // Issue and completion in the same cycle; multi-beat read.
    do_reset();
    s_aw_valid = 1; repeat (5) tick();
    b_valid = 1; b_ready = 1; tick(); b_valid = 0; b_ready = 0; s_aw_valid = 0;
    chk("wr_same_cycle_cnt", wr_ot_cnt, 5);
    s_ar_valid = 1; tick(); s_ar_valid = 0;
    chk("rd_issue_cnt", rd_ot_cnt, 1);
    r_valid = 1; r_ready = 1;
    for (int b = 0; b < 4; b++) begin
      r_last = (b == 3);
      tick();
      chk("rd_burst_cnt", rd_ot_cnt, (b == 3) ? 0 : 1);
    end
    r_valid = 0; r_ready = 0; r_last = 0;

    // Timeout latency, clear, and the disabled case.
    do_reset(); cfg_timeout = 100;
    s_aw_valid = 1; tick(); s_aw_valid = 0;
    n = 0;
    while (!wr_timeout && n < 200) begin tick(); n++; end
    chk("wr_timeout_latency", n, 101);
    clr_err = 1; tick(); clr_err = 0;
    chk("wr_timeout_cleared", wr_timeout, 0);
    cfg_timeout = 0; do_reset();
    s_aw_valid = 1; tick(); s_aw_valid = 0;
    repeat (300) tick();
    chk("wr_timeout_disabled", wr_timeout, 0);

    // Drain: block new issues, finish when both directions empty, then resume.
    do_reset();
    s_aw_valid = 1; s_ar_valid = 1; repeat (2) tick();
    s_ar_valid = 0; tick(); s_aw_valid = 0;
    drain_req = 1; tick();
    s_aw_valid = 1; s_ar_valid = 1; tick();
    chk("drain_block_aw", m_aw_valid, 0);
    chk("drain_block_ar", m_ar_valid, 0);
    chk("drain_hold_wcnt", wr_ot_cnt, 3);
    chk("drain_hold_rcnt", rd_ot_cnt, 2);
    b_valid = 1; b_ready = 1; r_valid = 1; r_ready = 1; r_last = 1;
    repeat (2) tick();
    r_valid = 0; tick(); b_valid = 0;
    chk("drain_empty_dd", drain_done, 0);
    tick();
    chk("drain_done_set", drain_done, 1);
    drain_req = 0; tick();
    chk("drain_resume_aw", m_aw_valid, 1);
    chk("drain_done_clear", drain_done, 0);
    tick(); s_aw_valid = 0; s_ar_valid = 0;

    // Underflow with nothing outstanding.
    do_reset();
    b_valid = 1; b_ready = 1; tick(); b_valid = 0;
    chk("uf_cnt", wr_ot_cnt, 0);
    repeat (3) tick();
    chk("uf_sticky", ot_underflow, 1);
    clr_err = 1; tick(); clr_err = 0;
    chk("uf_cleared", ot_underflow, 0);

    // Reset in the middle of traffic with a timeout pending.
    do_reset(); cfg_timeout = 5;
    for (int i = 0; i < 9; i++) begin s_aw_valid = (i < 7); s_ar_valid = 1; tick(); end
    s_aw_valid = 0; s_ar_valid = 0;
    n = 0;
    while (!wr_timeout && n < 50) begin tick(); n++; end
    chk("pre_rst_wto", wr_timeout, 1);
    chk("pre_rst_wcnt", wr_ot_cnt, 7);
    chk("pre_rst_rcnt", rd_ot_cnt, 9);
    rst = 1; tick(); rst = 0;
    chk("post_rst_wcnt", wr_ot_cnt, 0);
    chk("post_rst_rcnt", rd_ot_cnt, 0);
    chk("post_rst_wto", wr_timeout, 0);
    chk("post_rst_rto", rd_timeout, 0);
    b_valid = 1; b_ready = 1; tick(); b_valid = 0;
    chk("stale_b_uf", ot_underflow, 1);

    // Randomized traffic, checked only by the scoreboard.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) cfg_timeout = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(8, 40);
      s_aw_valid = ($urandom_range(0, 99) < 50);
      s_ar_valid = ($urandom_range(0, 99) < 50);
      m_aw_ready = ($urandom_range(0, 99) < 70);
      m_ar_ready = ($urandom_range(0, 99) < 70);
      t = {$urandom(), $urandom(), $urandom()}; s_aw_data = t[W-1:0];
      t = {$urandom(), $urandom(), $urandom()}; s_ar_data = t[W-1:0];
      b_valid = ($urandom_range(0, 99) < 35); b_ready = ($urandom_range(0, 99) < 80);
      r_valid = ($urandom_range(0, 99) < 50); r_ready = ($urandom_range(0, 99) < 80);
      r_last  = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      clr_err = ($urandom_range(0, 99) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    idle_inputs(); rst = 0;

    n = 0;
    while (expq.size() > 0 && n < 10) begin @(negedge aclk); n++; end
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
